dispense_controller: RTL and testbench

Downstream actuator stage for the vending machine controller. It accepts the vended product code and change-coin codes from the controller through ready/valid handshakes. Change codes are buffered in a small FIFO. The block then drives the product motors and coin ejectors with timed pulses, confirms each product drop with a sensor, and raises a sticky fault on a drop timeout.

---
 rtl/dispense_controller.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_dispense_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_controller.sv
// dispense_controller: actuator stage of the vending machine.
// Accepts one product request (single slot) and change coins (small FIFO),
// then sequences timed motor/ejector pulses, confirms product drops with a
// sensor and latches a fault when a drop never arrives.
// Optional feature: define DISPENSE_COUNT_EN to add the saturating
// vend_count/coin_count outputs.
module dispense_controller #(
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 16,
  parameter int DEPTH       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pro_in,
  input  logic        pro_valid,
  output logic        pro_ready,
  input  logic [2:0]  chg_in,
  input  logic        chg_valid,
  output logic        chg_ready,
  input  logic        prod_drop,
  input  logic        fault_clr,
  output logic [2:0]  prod_motor,
  output logic [3:0]  coin_eject,
  output logic        busy,
  output logic        fault
`ifdef DISPENSE_COUNT_EN
  ,
  output logic [15:0] vend_count,
  output logic [15:0] coin_count
`endif
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_PG  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_MAX = (MAX_PG > TIMEOUT_CYC) ? MAX_PG : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Terminal values of the shared phase counter for each timed state.
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   LVL_ONE    = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   LVL_FULL   = (PTR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PROD_DRIVE = 3'd1,
    ST_PROD_WAIT  = 3'd2,
    ST_COIN_DRIVE = 3'd3,
    ST_COIN_GAP   = 3'd4,
    ST_FAULT      = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slot_full_q, slot_full_d;
  logic [1:0]       slot_code_q, slot_code_d;
  logic [2:0]       prod_motor_q, prod_motor_d;
  logic [3:0]       coin_eject_q, coin_eject_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;

  logic [2:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             pro_fire;
  logic             chg_code_ok;
  logic             push;
  logic             pop;
  logic             drop_seen;
  logic [2:0]       head_code;
  logic [2:0]       prod_onehot;
  logic [3:0]       coin_onehot;

  assign fifo_full   = (count_q == LVL_FULL);
  assign fifo_empty  = (count_q == '0);
  assign pro_ready   = !slot_full_q && (state_q != ST_FAULT);
  assign chg_ready   = !fifo_full;
  assign pro_fire    = pro_valid && pro_ready;
  assign chg_code_ok = (chg_in >= 3'd1) && (chg_in <= 3'd4);
  assign push        = chg_valid && chg_ready && chg_code_ok;
  assign head_code   = fifo_mem[rd_ptr_q];
  // A drop only counts while the controller is actually waiting for one.
  assign drop_seen   = (state_q == ST_PROD_WAIT) && prod_drop;

  // Decode the slot product code and the FIFO head coin code to one-hot drives.
  always_comb begin
    prod_onehot = 3'b000;
    case (slot_code_q)
      2'b01:   prod_onehot = 3'b001;
      2'b10:   prod_onehot = 3'b010;
      2'b11:   prod_onehot = 3'b100;
      default: prod_onehot = 3'b000;
    endcase
    coin_onehot = 4'b0000;
    case (head_code)
      3'd1:    coin_onehot = 4'b0001;
      3'd2:    coin_onehot = 4'b0010;
      3'd3:    coin_onehot = 4'b0100;
      3'd4:    coin_onehot = 4'b1000;
      default: coin_onehot = 4'b0000;
    endcase
  end

  // Sequencer next state: arbitration in IDLE, timed pulses, drop wait, fault.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    slot_full_d  = slot_full_q;
    slot_code_d  = slot_code_q;
    prod_motor_d = 3'b000;
    coin_eject_d = 4'b0000;
    pop          = 1'b0;

    // A zero product code is consumed but never occupies the slot.
    if (pro_fire && (pro_in != 2'b00)) begin
      slot_full_d = 1'b1;
      slot_code_d = pro_in;
    end

    case (state_q)
      ST_IDLE: begin
        if (slot_full_q) begin
          state_d      = ST_PROD_DRIVE;
          cnt_d        = '0;
          prod_motor_d = prod_onehot;
        end else if (!fifo_empty) begin
          state_d      = ST_COIN_DRIVE;
          cnt_d        = '0;
          pop          = 1'b1;
          coin_eject_d = coin_onehot;
        end
      end
      ST_PROD_DRIVE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_PROD_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d        = cnt_q + CNT_ONE;
          prod_motor_d = prod_motor_q;
        end
      end
      ST_PROD_WAIT: begin
        // The drop has priority over a timeout expiring on the same edge.
        if (prod_drop) begin
          slot_full_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (cnt_q == TOUT_LAST) begin
          slot_full_d = 1'b0;
          state_d     = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_COIN_DRIVE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_COIN_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d        = cnt_q + CNT_ONE;
          coin_eject_d = coin_eject_q;
        end
      end
      ST_COIN_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Change FIFO pointers and occupancy; push and pop may coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + LVL_ONE;
    end else if (!push && pop) begin
      count_d = count_q - LVL_ONE;
    end
  end

  // Status outputs are registered, so derive them from the next-state values.
  always_comb begin
    busy_d  = (state_d != ST_IDLE) || slot_full_d || (count_d != '0);
    fault_d = (state_d == ST_FAULT);
  end

  // All sequencer, slot, FIFO-pointer and output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      slot_full_q  <= 1'b0;
      slot_code_q  <= 2'b00;
      prod_motor_q <= 3'b000;
      coin_eject_q <= 4'b0000;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      slot_full_q  <= slot_full_d;
      slot_code_q  <= slot_code_d;
      prod_motor_q <= prod_motor_d;
      coin_eject_q <= coin_eject_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= chg_in;
    end
  end

  assign prod_motor = prod_motor_q;
  assign coin_eject = coin_eject_q;
  assign busy       = busy_q;
  assign fault      = fault_q;

`ifdef DISPENSE_COUNT_EN
  logic [15:0] vend_count_q, vend_count_d;
  logic [15:0] coin_count_q, coin_count_d;

  // Saturating counts of confirmed drops and of coin ejections started.
  always_comb begin
    vend_count_d = vend_count_q;
    coin_count_d = coin_count_q;
    if (drop_seen && (vend_count_q != 16'hFFFF)) begin
      vend_count_d = vend_count_q + 16'd1;
    end
    if (pop && (coin_count_q != 16'hFFFF)) begin
      coin_count_d = coin_count_q + 16'd1;
    end
  end

  // Counter flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vend_count_q <= 16'd0;
      coin_count_q <= 16'd0;
    end else begin
      vend_count_q <= vend_count_d;
      coin_count_q <= coin_count_d;
    end
  end

  assign vend_count = vend_count_q;
  assign coin_count = coin_count_q;
`else
  logic unused_drop_seen;
  assign unused_drop_seen = drop_seen;
`endif

endmodule

// File: tb/tb_dispense_controller.sv
// Scoreboard bench for dispense_controller: stimulus pushes expected pulses
// into queues, a negedge monitor pops and compares each observed pulse.
module tb_dispense_controller;

  localparam int PULSE = 4;
  localparam int GAP   = 2;
  localparam int TOUT  = 16;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  pro_in;
  logic        pro_valid;
  logic        pro_ready;
  logic [2:0]  chg_in;
  logic        chg_valid;
  logic        chg_ready;
  logic        prod_drop;
  logic        fault_clr;
  logic [2:0]  prod_motor;
  logic [3:0]  coin_eject;
  logic        busy;
  logic        fault;
`ifdef DISPENSE_COUNT_EN
  logic [15:0] vend_count;
  logic [15:0] coin_count;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int coin_done = 0;
  int last_gap  = 0;

  logic [3:0] exp_coin_q[$];
  logic [2:0] exp_prod_q[$];

  dispense_controller #(
    .PULSE_CYC  (PULSE),
    .GAP_CYC    (GAP),
    .TIMEOUT_CYC(TOUT),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pro_in    (pro_in),
    .pro_valid (pro_valid),
    .pro_ready (pro_ready),
    .chg_in    (chg_in),
    .chg_valid (chg_valid),
    .chg_ready (chg_ready),
    .prod_drop (prod_drop),
    .fault_clr (fault_clr),
    .prod_motor(prod_motor),
    .coin_eject(coin_eject),
    .busy      (busy),
    .fault     (fault)
`ifdef DISPENSE_COUNT_EN
    ,
    .vend_count(vend_count),
    .coin_count(coin_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      tick();
      i++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  // Monitor: one line per observed pulse; compares code, width and stability.
  initial begin : monitor
    logic       coin_on, prod_on;
    int         coin_w, prod_w, coin_low;
    logic [3:0] cur_coin, ec;
    logic [2:0] cur_prod, ep;
    coin_on = 1'b0; prod_on = 1'b0;
    coin_w = 0; prod_w = 0; coin_low = 0;
    cur_coin = '0; cur_prod = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        coin_on = 1'b0; prod_on = 1'b0; coin_low = 0;
      end else begin
        if (coin_eject != 4'b0000) begin
          if (!coin_on) begin
            coin_on = 1'b1; coin_w = 1; cur_coin = coin_eject; last_gap = coin_low;
            if (exp_coin_q.size() == 0) begin
              check("coin_unexpected", {28'd0, coin_eject}, 32'd0);
            end else begin
              ec = exp_coin_q.pop_front();
              $display("coin pulse %b expected %b after %0d low cycles", coin_eject, ec, coin_low);
              check("coin_code", {28'd0, coin_eject}, {28'd0, ec});
            end
          end else begin
            coin_w++;
            check("coin_stable", {28'd0, coin_eject}, {28'd0, cur_coin});
          end
        end else if (coin_on) begin
          coin_on = 1'b0;
          check("coin_width", coin_w, PULSE);
          coin_done++;
          coin_low = 1;
        end else begin
          coin_low++;
        end

        if (prod_motor != 3'b000) begin
          if (!prod_on) begin
            prod_on = 1'b1; prod_w = 1; cur_prod = prod_motor;
            if (exp_prod_q.size() == 0) begin
              check("prod_unexpected", {29'd0, prod_motor}, 32'd0);
            end else begin
              ep = exp_prod_q.pop_front();
              $display("motor pulse %b expected %b", prod_motor, ep);
              check("prod_code", {29'd0, prod_motor}, {29'd0, ep});
            end
          end else begin
            prod_w++;
            check("prod_stable", {29'd0, prod_motor}, {29'd0, cur_prod});
          end
        end else if (prod_on) begin
          prod_on = 1'b0;
          check("prod_width", prod_w, PULSE);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base, i;
    logic got;
    reset = 1'b0; pro_in = 2'b00; pro_valid = 1'b0; chg_in = 3'b000; chg_valid = 1'b0;
    prod_drop = 1'b0; fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_motor", {29'd0, prod_motor}, 32'd0);
    check("rst_eject", {28'd0, coin_eject}, 32'd0);
    check("rst_pro_ready", {31'd0, pro_ready}, 32'd1);
    check("rst_chg_ready", {31'd0, chg_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single product, drop in first wait cycle.
    exp_prod_q.push_back(3'b010);
    pro_in = 2'b10; pro_valid = 1'b1;
    tick();                                   // edge 0: accepted
    pro_valid = 1'b0;
    check("t1_motor_e0", {29'd0, prod_motor}, 32'd0);
    check("t1_busy_e0", {31'd0, busy}, 32'd1);
    check("t1_pro_ready_e0", {31'd0, pro_ready}, 32'd0);
    for (int k = 1; k <= PULSE; k++) begin
      tick();
      check("t1_motor_on", {29'd0, prod_motor}, 32'b010);
    end
    tick();                                   // edge 5: PROD_WAIT
    check("t1_motor_off", {29'd0, prod_motor}, 32'd0);
    prod_drop = 1'b1;
    tick();
    prod_drop = 1'b0;
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    check("t1_fault", {31'd0, fault}, 32'd0);
    check("t1_pro_ready", {31'd0, pro_ready}, 32'd1);

    // Discarded codes.
    pro_in = 2'b00; pro_valid = 1'b1;
    tick();
    pro_valid = 1'b0;
    check("disc_pro_busy", {31'd0, busy}, 32'd0);
    chg_in = 3'b101; chg_valid = 1'b1;
    tick();
    chg_in = 3'b000;
    tick();
    chg_valid = 1'b0;
    repeat (3) tick();
    check("disc_chg_busy", {31'd0, busy}, 32'd0);
    check("disc_chg_eject", {28'd0, coin_eject}, 32'd0);

    // Three coins back to back.
    exp_coin_q.push_back(4'b0100); exp_coin_q.push_back(4'b0010); exp_coin_q.push_back(4'b0001);
    chg_valid = 1'b1;
    chg_in = 3'b011; tick();
    chg_in = 3'b010; tick();
    chg_in = 3'b001; tick();
    chg_valid = 1'b0;
    wait_idle("t2_idle", 100);
    check("t2_gap", last_gap, GAP + 1);

    // Five coins into a depth-4 FIFO while a product is pending.
    exp_prod_q.push_back(3'b001);
    prod_drop = 1'b1;
    pro_in = 2'b01; pro_valid = 1'b1;
    tick();
    pro_valid = 1'b0;
    exp_coin_q.push_back(4'b1000); exp_coin_q.push_back(4'b0001);
    exp_coin_q.push_back(4'b0100); exp_coin_q.push_back(4'b0010);
    chg_valid = 1'b1;
    chg_in = 3'b100; tick();
    chg_in = 3'b001; tick();
    chg_in = 3'b011; tick();
    chg_in = 3'b010; tick();
    check("t3_full", {31'd0, chg_ready}, 32'd0);
    exp_coin_q.push_back(4'b1000);
    chg_in = 3'b100;
    got = 1'b0;
    for (i = 0; i < 60 && !got; i++) begin
      if (chg_ready) begin
        check("t3_held_until_pop", {28'd0, coin_eject}, 32'b1000);
        got = 1'b1;
      end
      tick();
    end
    chg_valid = 1'b0;
    check("t3_fifth_accepted", {31'd0, got}, 32'd1);
    wait_idle("t3_idle", 200);
    prod_drop = 1'b0;

    // Drop timeout -> FAULT; queued coins held until fault_clr.
    exp_prod_q.push_back(3'b100);
    pro_in = 2'b11; pro_valid = 1'b1;
    tick();                                   // Q0
    pro_valid = 1'b0;
    exp_coin_q.push_back(4'b0010); exp_coin_q.push_back(4'b0001);
    chg_valid = 1'b1;
    chg_in = 3'b010; tick();                  // Q1
    chg_in = 3'b001; tick();                  // Q2
    chg_valid = 1'b0;
    tick(); tick();                           // Q3, Q4
    check("t4_motor_on", {29'd0, prod_motor}, 32'b100);
    tick();                                   // Q5
    check("t4_motor_off", {29'd0, prod_motor}, 32'd0);
    for (int k = 1; k < TOUT; k++) begin
      tick();
      check("t4_no_fault_yet", {31'd0, fault}, 32'd0);
    end
    tick();                                   // Q21
    check("t4_fault", {31'd0, fault}, 32'd1);
    check("t4_pro_ready", {31'd0, pro_ready}, 32'd0);
    check("t4_chg_ready", {31'd0, chg_ready}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_coins_held", {28'd0, coin_eject}, 32'd0);
    end
    check("t4_fault_sticky", {31'd0, fault}, 32'd1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("t4_fault_clr", {31'd0, fault}, 32'd0);
    check("t4_pro_ready_clr", {31'd0, pro_ready}, 32'd1);
    wait_idle("t4_idle", 100);

    // Drop on the same edge as the timeout wins.
    exp_prod_q.push_back(3'b010);
    pro_in = 2'b10; pro_valid = 1'b1;
    tick();                                   // Q0
    pro_valid = 1'b0;
    repeat (PULSE + 1) tick();                // Q1..Q5
    repeat (TOUT - 1) tick();                 // Q6..Q20
    prod_drop = 1'b1;
    tick();                                   // Q21
    prod_drop = 1'b0;
    check("t7_drop_wins_fault", {31'd0, fault}, 32'd0);
    check("t7_drop_wins_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset during COIN_DRIVE.
    exp_coin_q.push_back(4'b1000);
    chg_valid = 1'b1;
    chg_in = 3'b100; tick();                  // R0: pushed
    chg_in = 3'b011; tick();                  // R1: pop + push
    chg_valid = 1'b0;
    tick();                                   // R2
    check("t5_eject_before", {28'd0, coin_eject}, 32'b1000);
    #2 reset = 1'b0;
    #1;
    check("t5_eject_async", {28'd0, coin_eject}, 32'd0);
    check("t5_chg_ready", {31'd0, chg_ready}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (6) tick();
    check("t5_fifo_empty_eject", {28'd0, coin_eject}, 32'd0);
    check("t5_fifo_empty_busy", {31'd0, busy}, 32'd0);

    // Two products and three coins; second product arrives mid-coin.
    prod_drop = 1'b1;
    exp_prod_q.push_back(3'b001);
    pro_in = 2'b01; pro_valid = 1'b1;
    tick();
    pro_valid = 1'b0;
    exp_coin_q.push_back(4'b0001); exp_coin_q.push_back(4'b0010); exp_coin_q.push_back(4'b1000);
    chg_valid = 1'b1;
    chg_in = 3'b001; tick();
    chg_in = 3'b010; tick();
    chg_in = 3'b100; tick();
    chg_valid = 1'b0;
    i = 0;
    while (coin_eject == 4'b0000 && i < 50) begin tick(); i++; end
    check("t6_coin_started", {28'd0, coin_eject}, 32'b0001);
    base = coin_done;
    exp_prod_q.push_back(3'b100);
    check("t6_pro_ready_mid", {31'd0, pro_ready}, 32'd1);
    pro_in = 2'b11; pro_valid = 1'b1;
    tick();
    pro_valid = 1'b0;
    i = 0;
    while (prod_motor == 3'b000 && i < 50) begin tick(); i++; end
    check("t6_prod_after_one_coin", coin_done - base, 1);
    wait_idle("t6_idle", 200);
    prod_drop = 1'b0;
`ifdef DISPENSE_COUNT_EN
    check("t6_vend_count", {16'd0, vend_count}, 32'd2);
    check("t6_coin_count", {16'd0, coin_count}, 32'd3);
`endif

    repeat (3) tick();
    check("end_coin_queue", exp_coin_q.size(), 0);
    check("end_prod_queue", exp_prod_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
